// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the arithmetic reservation station.
// Tag 0 is reserved to mean "operand value already present".
package reservation_station_pkg;

  localparam int RS_SIZE  = 16;
  localparam int RS_IDX_W = 4;
  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 6;

  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [OP_W-1:0]     inst_t;
  typedef logic [RS_IDX_W-1:0] rs_idx_t;

  localparam rob_id_t ZERO_ROB = '0;

  typedef struct packed {
    inst_t   op;
    rob_id_t q1;
    rob_id_t q2;
    data_t   v1;
    data_t   v2;
    data_t   imm;
    data_t   pc;
    rob_id_t rob_id;
  } rs_entry_t;

  // A broadcast on tag 0 must never wake anything, since 0 means "no dependency".
  function automatic logic cdb_hit(input logic vld, input rob_id_t tag, input rob_id_t q);
    return vld && (tag != ZERO_ROB) && (tag == q);
  endfunction

endpackage

// File: rtl/rs_priority_sel.sv
// Lowest-index set-bit encoder over an RS_SIZE-bit vector; purely combinational.
// Reports whether any bit is set and the index of the lowest one.
module rs_priority_sel
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0]  vec,
  output logic                found,
  output logic [RS_IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = RS_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Arithmetic reservation station: 1 insert + 1 issue per cycle, issue is registered (insert-to-issue >= 1 cycle).
// rdy=0 freezes all state; rs_full is combinational from busy and a dispatch while full is dropped.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                disp_valid,
  input  logic [OP_W-1:0]     disp_op,
  input  logic [ROB_ID_W-1:0] disp_Q1,
  input  logic [ROB_ID_W-1:0] disp_Q2,
  input  logic [DATA_W-1:0]   disp_V1,
  input  logic [DATA_W-1:0]   disp_V2,
  input  logic [DATA_W-1:0]   disp_imm,
  input  logic [DATA_W-1:0]   disp_pc,
  input  logic [ROB_ID_W-1:0] disp_rob_id,
  output logic                rs_full,
  input  logic                valid_from_Arith_unit_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_Arith_unit_cdb,
  input  logic [DATA_W-1:0]   result_from_Arith_unit_cdb,
  input  logic                valid_from_LS_unit_cdb,
  input  logic [ROB_ID_W-1:0] rob_id_from_LS_unit_cdb,
  input  logic [DATA_W-1:0]   result_from_LS_unit_cdb,
  output logic                alu_valid,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_V1,
  output logic [DATA_W-1:0]   alu_V2,
  output logic [DATA_W-1:0]   alu_imm,
  output logic [DATA_W-1:0]   alu_pc,
  output logic [ROB_ID_W-1:0] alu_rob_id
);

  rs_entry_t          ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic               ready_found;
  rs_idx_t            free_idx;
  rs_idx_t            ready_idx;

  always_comb begin
    free_vec  = ~busy;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] && (ent[i].q1 == ZERO_ROB) && (ent[i].q2 == ZERO_ROB);
    end
  end

  rs_priority_sel u_free_sel (
    .vec   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_priority_sel u_ready_sel (
    .vec   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign rs_full = !free_found;

  // Insert targets a non-busy slot and issue a busy one, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_V1     <= '0;
      alu_V2     <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
      alu_rob_id <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i] <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            if (cdb_hit(valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, ent[i].q1)) begin
              ent[i].q1 <= ZERO_ROB;
              ent[i].v1 <= result_from_Arith_unit_cdb;
            end else if (cdb_hit(valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, ent[i].q1)) begin
              ent[i].q1 <= ZERO_ROB;
              ent[i].v1 <= result_from_LS_unit_cdb;
            end
            if (cdb_hit(valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb, ent[i].q2)) begin
              ent[i].q2 <= ZERO_ROB;
              ent[i].v2 <= result_from_Arith_unit_cdb;
            end else if (cdb_hit(valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb, ent[i].q2)) begin
              ent[i].q2 <= ZERO_ROB;
              ent[i].v2 <= result_from_LS_unit_cdb;
            end
          end
        end

        if (ready_found) begin
          busy[ready_idx] <= 1'b0;
          alu_valid       <= 1'b1;
          alu_op          <= ent[ready_idx].op;
          alu_V1          <= ent[ready_idx].v1;
          alu_V2          <= ent[ready_idx].v2;
          alu_imm         <= ent[ready_idx].imm;
          alu_pc          <= ent[ready_idx].pc;
          alu_rob_id      <= ent[ready_idx].rob_id;
        end else begin
          alu_valid <= 1'b0;
        end

        if (disp_valid && free_found) begin
          busy[free_idx] <= 1'b1;
          ent[free_idx]  <= '{op: disp_op, q1: disp_Q1, q2: disp_Q2, v1: disp_V1, v2: disp_V2,
                              imm: disp_imm, pc: disp_pc, rob_id: disp_rob_id};
        end
      end
    end
  end

endmodule
